// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, even parity and stop checks,
// one-entry valid/ready holding register. Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 sampling.
module uart_rx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        rx_err_parity_o,
  output logic        rx_err_frame_o,
  output logic        err_overrun_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY,
    STOP_BIT_FIRST,
    STOP_BIT_LAST
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        perr_out_q, perr_out_d;
  logic        ferr_out_q, ferr_out_d;
  logic        ovr_q, ovr_d;

  logic        fall;
  logic        fire;
  logic        sample;
  logic        complete;
  logic        drain;
  logic        frame_ferr;
  logic [15:0] target;
  logic [2:0]  last_idx;

  assign fall     = prev_q & ~sync2_q;
  assign last_idx = 3'd4 + {1'b0, cfg_bits_i};
  assign drain    = valid_q & rx_ready_i;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // The vote needs the value one cycle past the nominal centre, so the start
  // bit fires one cycle late and every later sample inherits that shift.
  assign target = (state_q == START_BIT) ? ({1'b0, cfg_div_i[15:1]} + 16'd1) : cfg_div_i;
  assign sample = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign target = (state_q == START_BIT) ? {1'b0, cfg_div_i[15:1]} : cfg_div_i;
  assign sample = sync2_q;
`endif

  assign fire = (cnt_q == target);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_d     = ferr_q;
    frame_ferr = ferr_q;
    complete   = 1'b0;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START_BIT;
          idx_d   = '0;
          shift_d = '0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START_BIT: begin
        if (fire) begin
          cnt_d   = '0;
          state_d = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (fire) begin
          cnt_d          = '0;
          shift_d[idx_q] = sample;
          par_d          = par_q ^ sample;
          if (idx_q == last_idx) begin
            state_d = cfg_parity_en_i ? PARITY : STOP_BIT_FIRST;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fire) begin
          cnt_d   = '0;
          par_d   = par_q ^ sample;
          state_d = STOP_BIT_FIRST;
        end
      end
      STOP_BIT_FIRST: begin
        if (fire) begin
          cnt_d      = '0;
          frame_ferr = ferr_q | ~sample;
          ferr_d     = frame_ferr;
          if (cfg_stop_bits_i) begin
            state_d = STOP_BIT_LAST;
          end else begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end
      end
      STOP_BIT_LAST: begin
        if (fire) begin
          cnt_d      = '0;
          frame_ferr = ferr_q | ~sample;
          ferr_d     = frame_ferr;
          state_d    = IDLE;
          complete   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!cfg_en_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      idx_d    = '0;
      complete = 1'b0;
    end

    if (drain) valid_d = 1'b0;

    // A draining register can take the new frame on the same edge.
    if (complete) begin
      if (!valid_q || drain) begin
        data_d     = shift_q;
        perr_out_d = cfg_parity_en_i & par_q;
        ferr_out_d = frame_ferr;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      hist_q     <= 2'b11;
`endif
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= rx_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
      hist_q     <= {hist_q[0], sync2_q};
`endif
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data_o       = data_q;
  assign rx_valid_o      = valid_q;
  assign rx_err_parity_o = perr_out_q;
  assign rx_err_frame_o  = ferr_out_q;
  assign err_overrun_o   = ovr_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference queue, directed cases and
// randomized framing configurations with a randomized consumer.
module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_i;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic        cfg_parity_en_i;
  logic [1:0]  cfg_bits_i;
  logic        cfg_stop_bits_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        rx_err_parity_o;
  logic        rx_err_frame_o;
  logic        err_overrun_o;
  logic        busy_o;

  uart_rx dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rx_i            (rx_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_div_i       (cfg_div_i),
    .cfg_parity_en_i (cfg_parity_en_i),
    .cfg_bits_i      (cfg_bits_i),
    .cfg_stop_bits_i (cfg_stop_bits_i),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .rx_err_parity_o (rx_err_parity_o),
    .rx_err_frame_o  (rx_err_frame_o),
    .err_overrun_o   (err_overrun_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  frame_t     exp_q[$];
  int         n_checks  = 0;
  int         n_pass    = 0;
  int         ovr_seen  = 0;
  int         ovr_exp   = 0;
  int         hs_count  = 0;
  logic [7:0] last_data = 8'h00;
  bit         rand_ready  = 1'b0;
  bit         ready_fixed = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    else n_pass++;
  endtask

  // Consumer: either a fixed level or a coin flip each cycle.
  initial begin
    rx_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #2;
      rx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Compare process: every handshake must deliver the oldest expected frame,
  // and a held frame must not move.
  initial begin
    frame_t     f;
    bit         hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        hold_prev = 1'b0;
      end else begin
        if (rx_valid_o && rx_ready_i) begin
          hs_count++;
          last_data = rx_data_o;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            f = exp_q.pop_front();
            check("rx_data", 32'(rx_data_o), 32'(f.data));
            check("rx_err_parity", 32'(rx_err_parity_o), 32'(f.perr));
            check("rx_err_frame", 32'(rx_err_frame_o), 32'(f.ferr));
          end
        end
        if (err_overrun_o) ovr_seen++;
        if (hold_prev) begin
          check("hold_valid", 32'(rx_valid_o), 32'd1);
          check("hold_data", 32'(rx_data_o), 32'(hold_data));
        end
        hold_prev = rx_valid_o && !rx_ready_i;
        hold_data = rx_data_o;
      end
    end
  end

  task automatic align();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_bit(input bit v, input bit glitch, input int per);
    for (int k = 0; k < per; k++) begin
      rx_i = (glitch && k == per / 2) ? ~v : v;
      @(posedge clk_i);
      #1;
    end
  endtask

  // Sends one frame with the current configuration; if deliver is set the
  // expected result is derived from the framing rules and queued.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pflip,
                            input bit s0, input bit s1, input bit glitch, input bit deliver);
    int         per;
    bit         p;
    logic [7:0] mask;
    frame_t     f;
    per  = int'(cfg_div_i) + 1;
    mask = 8'hFF >> (8 - nb);
    p    = pflip;
    for (int i = 0; i < nb; i++) p ^= d[i];
    if (deliver) begin
      f.data = d & mask;
      f.perr = cfg_parity_en_i & pflip;
      f.ferr = !s0 || (cfg_stop_bits_i && !s1);
      exp_q.push_back(f);
    end
    drive_bit(1'b0, glitch, per);
    for (int i = 0; i < nb; i++) drive_bit(d[i], glitch, per);
    if (cfg_parity_en_i) drive_bit(p, glitch, per);
    drive_bit(s0, 1'b0, per);
    if (cfg_stop_bits_i) drive_bit(s1, 1'b0, per);
    drive_bit(1'b1, 1'b0, 2 * per);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (rx_valid_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    check("drain", 32'(rx_valid_o), 32'd0);
  endtask

  task automatic set_ready(input bit r);
    ready_fixed = r;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int hs0;
    rst_i           = 1'b1;
    rx_i            = 1'b1;
    cfg_en_i        = 1'b1;
    cfg_div_i       = 16'd15;
    cfg_parity_en_i = 1'b0;
    cfg_bits_i      = 2'b11;
    cfg_stop_bits_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_valid", 32'(rx_valid_o), 32'd0);
    check("reset_data", 32'(rx_data_o), 32'd0);
    check("reset_perr", 32'(rx_err_parity_o), 32'd0);
    check("reset_ferr", 32'(rx_err_frame_o), 32'd0);
    check("reset_ovr", 32'(err_overrun_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);

    // 8N1 0xA5 with ready high: exactly one transfer.
    align();
    hs0 = hs_count;
    send_frame(8'hA5, 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk_i);
    check("a5_transfers", 32'(hs_count - hs0), 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_busy_idle", 32'(busy_o), 32'd0);

    // 7E2 0x55 with a wrong parity bit.
    cfg_bits_i      = 2'b10;
    cfg_parity_en_i = 1'b1;
    cfg_stop_bits_i = 1'b1;
    set_ready(1'b0);
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk_i);
    check("7e2_valid", 32'(rx_valid_o), 32'd1);
    check("7e2_data", 32'(rx_data_o), 32'h55);
    check("7e2_perr", 32'(rx_err_parity_o), 32'd1);
    check("7e2_ferr", 32'(rx_err_frame_o), 32'd0);
    set_ready(1'b1);
    wait_drain();

    // 5N1 0x1F with a low stop bit.
    cfg_bits_i      = 2'b00;
    cfg_parity_en_i = 1'b0;
    cfg_stop_bits_i = 1'b0;
    set_ready(1'b0);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk_i);
    check("5n1_valid", 32'(rx_valid_o), 32'd1);
    check("5n1_data", 32'(rx_data_o), 32'h1F);
    check("5n1_ferr", 32'(rx_err_frame_o), 32'd1);
    check("5n1_perr", 32'(rx_err_parity_o), 32'd0);
    set_ready(1'b1);
    wait_drain();

    // 4-clock low spike is rejected at the half-bit sample.
    cfg_bits_i = 2'b11;
    align();
    hs0  = hs_count;
    rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    @(negedge clk_i);
    check("spike_busy_high", 32'(busy_o), 32'd1);
    repeat (16) @(posedge clk_i);
    @(negedge clk_i);
    check("spike_busy_low", 32'(busy_o), 32'd0);
    check("spike_valid", 32'(rx_valid_o), 32'd0);
    check("spike_no_frame", 32'(hs_count - hs0), 32'd0);

    // Overrun: second frame dropped, first kept.
    set_ready(1'b0);
    send_frame(8'h11, 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    ovr_exp++;
    @(negedge clk_i);
    check("ovr_valid", 32'(rx_valid_o), 32'd1);
    check("ovr_data_kept", 32'(rx_data_o), 32'h11);
    check("ovr_pulses", 32'(ovr_seen), 32'd1);
    set_ready(1'b1);
    wait_drain();
    check("ovr_transfer", 32'(last_data), 32'h11);

    // Receiver disabled: a full frame is ignored.
    cfg_en_i = 1'b0;
    align();
    hs0 = hs_count;
    send_frame(8'h5A, 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    check("dis_busy", 32'(busy_o), 32'd0);
    check("dis_no_frame", 32'(hs_count - hs0), 32'd0);
    cfg_en_i = 1'b1;

    // Reset mid-DATA of 0x3C, then 0xC3 is the only delivery.
    align();
    hs0 = hs_count;
    drive_bit(1'b0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(1'($unsigned(8'h3C >> i)), 1'b0, 16);
    rx_i  = 1'b1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_busy_before", 32'(busy_o), 32'd1);
    align();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_valid", 32'(rx_valid_o), 32'd0);
    align();
    drive_bit(1'b1, 1'b0, 32);
    send_frame(8'hC3, 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk_i);
    check("midrst_transfers", 32'(hs_count - hs0), 32'd1);
    check("midrst_data", 32'(last_data), 32'hC3);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-clock glitch at the centre of every bit is outvoted.
    align();
    hs0 = hs_count;
    send_frame(8'hA5, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk_i);
    check("vote_transfers", 32'(hs_count - hs0), 32'd1);
    check("vote_data", 32'(last_data), 32'hA5);
`endif

    // Randomized framing, data, errors and consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      wait_drain();
      cfg_div_i       = 16'($urandom_range(4, 20));
      cfg_bits_i      = 2'($urandom_range(0, 3));
      cfg_parity_en_i = 1'($urandom_range(0, 1));
      cfg_stop_bits_i = 1'($urandom_range(0, 1));
      align();
      send_frame(8'($urandom_range(0, 255)), 5 + int'(cfg_bits_i),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), 1'b0, 1'b1);
    end
    rand_ready = 1'b0;
    set_ready(1'b1);
    wait_drain();
    @(negedge clk_i);
    check("all_frames_delivered", 32'(exp_q.size()), 32'd0);
    check("overrun_total", 32'(ovr_seen), 32'(ovr_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
